// File: rtl/encoder_seq_ctrl_pkg.sv
// Shared encoding for the encoder sequencer: FSM states, lane geometry and a
// small helper that identifies the states that walk the lane counter.
package enc_pkg;

  localparam int LANES = 64;
  localparam int LIW   = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ROUND = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // LOAD, ROUND and WRITE all sweep lanes 0..63 and honour hold.
  function automatic logic is_pass_state(input state_e st);
    logic res;
    case (st)
      ST_LOAD, ST_ROUND, ST_WRITE: res = 1'b1;
      default:                     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lane_idx_counter.sv
// Lane index counter shared by the LOAD, ROUND and WRITE passes.
// Counts 0..64; carry marks the extra terminal cycle at 64, and clear wins over enable.
module lane_idx_counter
  import enc_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [LIW-1:0] idx_o,
  output logic           carry_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          carry_s;

  assign carry_s = (cnt_q == CW'(LANES));

  // Next count: clear first, then increment, never stepping past 64.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !carry_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx_o   = cnt_q[LIW-1:0];
  assign carry_o = carry_s;

endmodule

// File: rtl/encoder_seq_ctrl.sv
// Job sequencer for the 64-lane encoder: LOAD 64 words, NR rounds of 64 lane
// steps, WRITE 64 words, then a one-cycle done pulse.
module encoder_seq_ctrl
  import enc_pkg::*;
#(
  parameter int NR = 24,
  parameter int RW = 5,
  parameter int CW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           soft_clr,
  input  logic           hold,
  output logic           ready,
  output logic           done,
  output logic           in_rd_en,
  output logic [LIW-1:0] in_addr,
  output logic           lane_en,
  output logic [LIW-1:0] lane_idx,
  output logic [RW-1:0]  round_idx,
  output logic           first_rnd,
  output logic           out_wr_en,
  output logic [LIW-1:0] out_addr
);

  state_e         state_q;
  state_e         state_d;
  logic [RW-1:0]  round_q;
  logic [RW-1:0]  round_d;
  logic           lane_clr_s;
  logic           lane_inc_s;
  logic           lane_carry_s;
  logic [LIW-1:0] lane_s;
  logic           step_ok_s;

  lane_idx_counter #(.CW(CW)) u_lane_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (lane_clr_s),
    .en_i    (lane_inc_s),
    .idx_o   (lane_s),
    .carry_o (lane_carry_s)
  );

  // Next-state, round counter and lane counter control.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    lane_clr_s = 1'b0;
    lane_inc_s = 1'b0;
    if (soft_clr) begin
      state_d    = ST_IDLE;
      round_d    = '0;
      lane_clr_s = 1'b1;
    end else if (is_pass_state(state_q) && hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_INIT;
          else       state_d = ST_IDLE;
        end
        ST_INIT: begin
          lane_clr_s = 1'b1;
          round_d    = '0;
          state_d    = ST_LOAD;
        end
        ST_LOAD: begin
          if (lane_carry_s) begin
            lane_clr_s = 1'b1;
            state_d    = ST_ROUND;
          end else begin
            lane_inc_s = 1'b1;
          end
        end
        ST_ROUND: begin
          if (!lane_carry_s) begin
            lane_inc_s = 1'b1;
          end else if (round_q == RW'(NR - 1)) begin
            lane_clr_s = 1'b1;
            round_d    = '0;
            state_d    = ST_WRITE;
          end else begin
            lane_clr_s = 1'b1;
            round_d    = round_q + RW'(1);
          end
        end
        ST_WRITE: begin
          if (lane_carry_s) begin
            lane_clr_s = 1'b1;
            state_d    = ST_DONE;
          end else begin
            lane_inc_s = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: begin
          state_d    = ST_IDLE;
          round_d    = '0;
          lane_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State and round registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Strobes come from registered state; hold and abort only suppress them.
  assign step_ok_s = !lane_carry_s && !hold && !soft_clr;

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign in_rd_en  = (state_q == ST_LOAD)  && step_ok_s;
  assign lane_en   = (state_q == ST_ROUND) && step_ok_s;
  assign out_wr_en = (state_q == ST_WRITE) && step_ok_s;
  assign first_rnd = (state_q == ST_ROUND) && (round_q == '0);
  assign in_addr   = lane_s;
  assign lane_idx  = lane_s;
  assign out_addr  = lane_s;
  assign round_idx = round_q;

endmodule
